// File: rtl/rr_quantum_arbiter.sv
// rtl/rr_quantum_arbiter.sv - four-way round-robin arbiter with per-grant time quantum
module rr_quantum_arbiter #(
  parameter int NREQ    = 4,
  parameter int QUANTUM = 8,
  parameter int CW      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_id,
  output logic            busy,
  output logic            expired
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      gnt_id_q, gnt_id_d;
  logic            busy_q, busy_d;
  logic            expired_q, expired_d;

  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] others;

  // First set bit of v searching p+1, p+2, p+3, p (mod 4); the descending
  // loop lets the nearest candidate overwrite farther ones.
  function automatic logic [1:0] pick(input logic [NREQ-1:0] v, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    win = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (v[idx]) win = idx;
    end
    return win;
  endfunction

  assign own_oh = NREQ'(1) << owner_q;
  assign others = req & ~own_oh;

  // Next-state: grant selection, hand-off, quantum pre-emption and output image
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    expired_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          state_d = S_GRANT;
          owner_d = pick(req, last_q);
          cnt_d   = CW'(1);
        end
      end
      S_GRANT: begin
        if (!req[owner_q]) begin
          // Owner released: hand straight to the next waiter, or go idle
          last_d = owner_q;
          if (others != '0) begin
            owner_d = pick(others, owner_q);
            cnt_d   = CW'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if ((cnt_q >= CW'(QUANTUM)) && (others != '0)) begin
          // Quantum used up while someone else waits: rotate
          last_d    = owner_q;
          owner_d   = pick(others, owner_q);
          cnt_d     = CW'(1);
          expired_d = 1'b1;
        end else if (cnt_q < CW'(QUANTUM)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    gnt_d    = (state_d == S_GRANT) ? (NREQ'(1) << owner_d) : '0;
    gnt_id_d = (state_d == S_GRANT) ? owner_d : 2'd0;
    busy_d   = (state_d == S_GRANT);
  end

  // State and registered outputs; last=3 so requester 0 wins first after reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 2'd0;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      gnt_q     <= '0;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// tb/tb_rr_quantum_arbiter.sv - directed and randomized check of rr_quantum_arbiter against a reference model
module tb_rr_quantum_arbiter;

  localparam int Q     = 8;
  localparam int BOUND = 3 * Q + 1;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       expired;

  rr_quantum_arbiter #(.NREQ(4), .QUANTUM(Q), .CW(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .expired (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: who owns, how long it has held, who owned last
  bit m_busy;
  int m_owner;
  int m_held;
  int m_last;
  bit m_exp;

  int         wait_cnt [4];
  logic [3:0] prev_req;
  logic [3:0] prev_gnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_next(input logic [3:0] v, input int p);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (p + k) % 4;
      if (v[idx]) return idx;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_held  = 0;
    m_last  = 3;
    m_exp   = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    m_exp = 1'b0;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        m_busy  = 1'b1;
        m_owner = rr_next(r, m_last);
        m_held  = 1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_last = m_owner;
        if (others != 4'b0000) begin
          m_owner = rr_next(others, m_owner);
          m_held  = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_held >= Q && others != 4'b0000) begin
        m_last  = m_owner;
        m_owner = rr_next(others, m_owner);
        m_held  = 1;
        m_exp   = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  // one clock: drive req, advance model at the edge, compare just after it
  task automatic cycle(input logic [3:0] r);
    logic [3:0] eg;
    req = r;
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      chk("wait_bound", int'(wait_cnt[i] <= BOUND), 1);
    end
    prev_req = r;
    prev_gnt = gnt;
    @(posedge clock);
    model_step(r);
    #1;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", gnt, eg);
    chk("gnt_id", gnt_id, m_busy ? m_owner : 0);
    chk("busy", busy, m_busy);
    chk("expired", expired, m_exp);
    chk("onehot", int'($countones(gnt) <= 1), 1);
    chk("gnt_in_req", int'((gnt & ~prev_req) == 4'b0000), 1);
    if (expired) chk("expired_moves", int'(gnt != prev_gnt), 1);
  endtask

  task automatic do_reset();
    req = 4'b0000;
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
  endtask

  logic [3:0] r;

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_expired", expired, 0);
    reset = 1'b1;

    // zero-bubble handoff
    cycle(4'b0110);
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_gnt_id", gnt_id, 1);
    chk("t1_busy", busy, 1);
    cycle(4'b0110);
    cycle(4'b0100);
    chk("t1_handoff", gnt, 4'b0100);
    chk("t1_handoff_id", gnt_id, 2);

    // full contention rotates every Q cycles
    do_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(4'b1111);
      chk("t2_gnt", gnt, 4'b0001 << ((k / Q) % 4));
      chk("t2_expired", expired, int'(k > 0 && (k % Q) == 0));
    end

    // lone requester keeps the grant indefinitely
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0001);
      chk("t3_gnt", gnt, 4'b0001);
      chk("t3_expired", expired, 0);
    end
    cycle(4'b0000);
    chk("t3_release", gnt, 0);
    chk("t3_busy", busy, 0);

    // search resumes after the releasing owner
    do_reset();
    cycle(4'b0100);
    chk("t4_own2", gnt, 4'b0100);
    cycle(4'b0100);
    cycle(4'b1001);
    chk("t4_next", gnt, 4'b1000);

    // asynchronous reset mid-grant
    do_reset();
    for (int k = 0; k < 13; k++) cycle(4'b1111);
    chk("t5_pre", gnt, 4'b0010);
    #1 reset = 1'b0;
    #1;
    chk("t5_gnt", gnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_gnt_id", gnt_id, 0);
    chk("t5_expired", expired, 0);
    #2 reset = 1'b1;
    model_reset();
    cycle(4'b1111);
    chk("t5_first", gnt, 4'b0001);

    // randomized traffic: waiters mostly persist, owners release sometimes
    r = 4'b1111;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) begin
          if (gnt[i]) r[i] = ($urandom_range(0, 7) != 0);
          else r[i] = ($urandom_range(0, 31) != 0);
        end else begin
          r[i] = ($urandom_range(0, 3) == 0);
        end
      end
      cycle(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_quantum_arbiter.md
Name: rr_quantum_arbiter

Overview:
- Four-requester round-robin arbiter with a per-grant time quantum, for sharing one resource among FSM-based clients.
- Replaces fixed-priority two-way arbitration where more clients contend and starvation must be bounded.
- Grants are registered and one-hot.
- The owner keeps the grant while its request stays high, but is pre-empted after QUANTUM cycles if another requester is waiting.

Parameters:
- NREQ, 4, number of requesters (design and tests fixed at 4)
- QUANTUM, 8, maximum grant cycles before pre-emption when contended (legal range 1..15)
- CW, 4, quantum counter width; must satisfy 2^CW > QUANTUM

Ports:
- clock  input  1  single rising-edge clock
- reset  input  1  asynchronous, active-low reset; low clears all state immediately
- req  input  4  request vector, bit i = requester i; level-sensitive
- gnt  output  4  registered one-hot grant, or all-zero
- gnt_id  output  2  index of current owner; 0 when gnt==0
- busy  output  1  high when any gnt bit is high
- expired  output  1  one-cycle pulse on the cycle the grant moves because of quantum pre-emption

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt=0, gnt_id=0, busy=0, expired=0.
  - State=IDLE, cnt=0, last=3, so requester 0 wins first after reset.
- State machine:
  - Two states: IDLE and GRANT.
  - Registers: owner[1:0], cnt[CW-1:0], last[1:0]. All outputs are registered.
- Winner function pick(v, p): first set bit of v, searching p+1, p+2, p+3, p (mod 4).
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: GRANT with owner=pick(req, last), cnt=1, gnt=onehot(owner) on the next edge.
  - Latency from req high to gnt high is 1 cycle.
- GRANT, evaluated at each edge with others = req & ~onehot(owner):
  - a) req[owner]==0 and others!=0: owner=pick(others, owner), cnt=1, last=old owner. Zero-bubble handoff; expired=0.
  - b) req[owner]==0 and others==0: go to IDLE; gnt=0 next cycle; last=old owner.
  - c) req[owner]==1, cnt>=QUANTUM, others!=0: pre-empt. owner=pick(others, owner), cnt=1, last=old owner, expired=1 for exactly this next cycle.
  - d) req[owner]==1 otherwise: hold the grant; cnt=min(cnt+1, QUANTUM), saturating.
- Exactly one gnt bit is ever high. gnt never moves to a requester whose req is low at the deciding edge.
- A pre-empted requester that keeps req high is re-granted only after every other active requester has been served, which follows from round-robin order.
- Worst-case wait for a continuously requesting client: 3*QUANTUM+1 cycles after its req rises while another holds the grant.
- Simultaneous release and new requests are handled by rule a); no IDLE cycle is inserted.
- Async reset during GRANT:
  - Outputs drop combinationally with reset.
  - After reset deasserts, the first grant follows the IDLE rule with last=3.
- QUANTUM==1: a contended grant lasts exactly 1 cycle, giving strict rotation.

Test Plan:
1. Reset, then req=4'b0110 held for 2 cycles. Requires gnt=0010 one cycle after req, gnt_id=1, busy=1. Drop req[1]: next cycle gnt=0100, gnt_id=2, no idle gap.
2. req=4'b1111 held constant, QUANTUM=8. Requires grant sequence 0001, 0010, 0100, 1000, 0001, each lasting exactly 8 cycles, with expired pulsing once at each change.
3. req=4'b0001 alone for 20 cycles. Requires gnt=0001 throughout, expired never high, cnt saturates at 8. Drop req: gnt=0 on the next cycle, busy=0.
4. Owner 2 holds the grant. Raise req[0] and req[3] on the same edge on which req[2] drops. Requires gnt=1000 next cycle (search starts after 2).
5. req=4'b1111 in mid-grant at cycle 5 of owner 1. Pulse reset low for 3 ns between clock edges. Requires gnt/busy/gnt_id/expired=0 immediately. After release, the first grant is 0001.
6. Randomized req for 10k cycles. Check:
   - gnt is always one-hot or zero, and gnt ⊆ req of the previous cycle.
   - No requester waits more than 3*QUANTUM+1 cycles while req is high.
   - expired is only high on cycles where gnt changed.
